// File: rtl/midway8080_video_pkg.sv
// Shared 640x480@60 VGA timing constants and the 224x256 Midway game-window geometry.
// Also holds the sync bundle carried through the read-latency delay line.
package midway8080_video_pkg;

   localparam int unsigned H_VISIBLE    = 640;
   localparam int unsigned H_TOTAL      = 800;
   localparam int unsigned HS_START     = 656;
   localparam int unsigned HS_END       = 751;
   localparam int unsigned V_VISIBLE    = 480;
   localparam int unsigned V_TOTAL      = 525;
   localparam int unsigned VS_START     = 490;
   localparam int unsigned VS_END       = 491;
   localparam int unsigned GAME_W       = 224;
   localparam int unsigned GAME_H       = 256;
   localparam int unsigned IRQ_MID_LINE = 128;

   localparam int unsigned CNT_W = 10;

   typedef logic [CNT_W-1:0] cnt_t;

   // Coordinates reported to the memory adapter when the beam is outside the window
   localparam logic [9:0] PIX_X_OFF = 10'd1023;
   localparam logic [8:0] PIX_Y_OFF = 9'd511;

   // Active-high "in sync pulse" flags so an all-zero (reset) delay line means idle syncs
   typedef struct packed {
      logic hs_on;
      logic vs_on;
      logic act;
   } sync_t;

   function automatic logic in_span(input cnt_t val, input cnt_t lo, input cnt_t hi);
      return (val >= lo) && (val <= hi);
   endfunction

endpackage

// File: rtl/midway8080_vga_scanout_if.sv
// Raster timing bus from the VGA timing generator to the scanout top.
// Carries the pixel phase, beam counters and the undelayed sync/active flags.
interface midway8080_vga_scanout_if;
   import midway8080_video_pkg::*;

   logic phase;
   cnt_t h_count;
   cnt_t v_count;
   logic hsync_raw;
   logic vsync_raw;
   logic active_raw;

   modport master (
      output phase,
      output h_count,
      output v_count,
      output hsync_raw,
      output vsync_raw,
      output active_raw
   );

   modport slave (
      input phase,
      input h_count,
      input v_count,
      input hsync_raw,
      input vsync_raw,
      input active_raw
   );

endinterface

// File: rtl/midway8080_vga_timing.sv
// 640x480 raster generator: divide-by-two pixel phase, h/v beam counters and raw syncs.
// A pixel tick is any clk edge where phase is 1; counters only move on ticks.
module midway8080_vga_timing
   import midway8080_video_pkg::*;
(
   input  logic                            clk,
   input  logic                            reset_n,
   midway8080_vga_scanout_if.master        tim
);

   logic r_phase;
   cnt_t r_h;
   cnt_t r_v;

   logic w_h_wrap;
   logic w_v_wrap;

   assign w_h_wrap = (r_h == cnt_t'(H_TOTAL - 1));
   assign w_v_wrap = (r_v == cnt_t'(V_TOTAL - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_phase <= 1'b0;
         r_h     <= '0;
         r_v     <= '0;
      end else begin
         r_phase <= ~r_phase;
         if (r_phase) begin
            if (w_h_wrap) begin
               r_h <= '0;
               r_v <= w_v_wrap ? '0 : r_v + cnt_t'(1);
            end else begin
               r_h <= r_h + cnt_t'(1);
            end
         end
      end
   end

   // Raw syncs are active-low and purely decoded from the current counters
   assign tim.phase      = r_phase;
   assign tim.h_count    = r_h;
   assign tim.v_count    = r_v;
   assign tim.hsync_raw  = ~in_span(r_h, cnt_t'(HS_START), cnt_t'(HS_END));
   assign tim.vsync_raw  = ~in_span(r_v, cnt_t'(VS_START), cnt_t'(VS_END));
   assign tim.active_raw = (r_h < cnt_t'(H_VISIBLE)) && (r_v < cnt_t'(V_VISIBLE));

endmodule

// File: rtl/midway8080_vga_scanout.sv
// Midway 8080 video scanout: maps the VGA beam onto the 224x256 game window, delays syncs
// by the adapter read latency RD_LAT (legal 1..3) and registers DAC outputs and 8080 IRQs.
module midway8080_vga_scanout
   import midway8080_video_pkg::*;
#(
   parameter int unsigned H_START = 208,
   parameter int unsigned V_START = 112,
   parameter int unsigned RD_LAT  = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [9:0]  pix_x,
   output logic [8:0]  pix_y,
   input  logic [31:0] rgb_in,
   output logic [7:0]  vga_r,
   output logic [7:0]  vga_g,
   output logic [7:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic        vga_sync_n,
   output logic        vga_clk,
   output logic        irq_mid,
   output logic        irq_vblank
);

   localparam cnt_t LP_H_LO  = cnt_t'(H_START);
   localparam cnt_t LP_H_HI  = cnt_t'(H_START + GAME_W - 1);
   localparam cnt_t LP_V_LO  = cnt_t'(V_START);
   localparam cnt_t LP_V_HI  = cnt_t'(V_START + GAME_H - 1);
   localparam cnt_t LP_V_MID = cnt_t'(V_START + IRQ_MID_LINE);
   localparam cnt_t LP_V_VBL = cnt_t'(V_START + GAME_H);

   midway8080_vga_scanout_if u_tim_if ();

   midway8080_vga_timing u_timing (
      .clk     (clk),
      .reset_n (reset_n),
      .tim     (u_tim_if.master)
   );

   logic  w_tick;
   cnt_t  w_h;
   cnt_t  w_v;
   logic  w_in_win;
   sync_t w_sync_raw;
   sync_t w_sync_dly;
   logic  w_unused_rgb;

   assign w_tick = u_tim_if.phase;
   assign w_h    = u_tim_if.h_count;
   assign w_v    = u_tim_if.v_count;

   always_comb begin
      w_in_win         = in_span(w_h, LP_H_LO, LP_H_HI) && in_span(w_v, LP_V_LO, LP_V_HI);
      w_sync_raw       = '0;
      w_sync_raw.hs_on = ~u_tim_if.hsync_raw;
      w_sync_raw.vs_on = ~u_tim_if.vsync_raw;
      w_sync_raw.act   = u_tim_if.active_raw;
   end

   // The adapter only supplies 10-bit channels; the DAC takes the top 8 of each
   assign w_unused_rgb = ^{rgb_in[31:30], rgb_in[21:20], rgb_in[11:10], rgb_in[1:0]};

   logic [9:0] r_pix_x;
   logic [8:0] r_pix_y;
   sync_t      r_dly [RD_LAT];
   logic [7:0] r_vga_r;
   logic [7:0] r_vga_g;
   logic [7:0] r_vga_b;
   logic       r_vga_hs;
   logic       r_vga_vs;
   logic       r_blank_n;
   logic       r_irq_mid;
   logic       r_irq_vblank;

   assign w_sync_dly = r_dly[RD_LAT-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pix_x      <= PIX_X_OFF;
         r_pix_y      <= PIX_Y_OFF;
         for (int i = 0; i < RD_LAT; i++) r_dly[i] <= '0;
         r_vga_r      <= '0;
         r_vga_g      <= '0;
         r_vga_b      <= '0;
         r_vga_hs     <= 1'b1;
         r_vga_vs     <= 1'b1;
         r_blank_n    <= 1'b0;
         r_irq_mid    <= 1'b0;
         r_irq_vblank <= 1'b0;
      end else begin
         // Gated by the tick, so these fall again on the following non-tick clk
         r_irq_mid    <= w_tick && (w_h == '0) && (w_v == LP_V_MID);
         r_irq_vblank <= w_tick && (w_h == '0) && (w_v == LP_V_VBL);
         if (w_tick) begin
            r_pix_x <= w_in_win ? (w_h - LP_H_LO) : PIX_X_OFF;
            r_pix_y <= w_in_win ? 9'(w_v - LP_V_LO) : PIX_Y_OFF;
            for (int i = RD_LAT - 1; i > 0; i--) r_dly[i] <= r_dly[i-1];
            r_dly[0] <= w_sync_raw;
            // rgb_in now belongs to the coordinates issued RD_LAT ticks ago
            r_vga_r   <= w_sync_dly.act ? rgb_in[29:22] : 8'd0;
            r_vga_g   <= w_sync_dly.act ? rgb_in[19:12] : 8'd0;
            r_vga_b   <= w_sync_dly.act ? rgb_in[9:2]   : 8'd0;
            r_vga_hs  <= ~w_sync_dly.hs_on;
            r_vga_vs  <= ~w_sync_dly.vs_on;
            r_blank_n <= w_sync_dly.act;
         end
      end
   end

   assign pix_x       = r_pix_x;
   assign pix_y       = r_pix_y;
   assign vga_r       = r_vga_r;
   assign vga_g       = r_vga_g;
   assign vga_b       = r_vga_b;
   assign vga_hs      = r_vga_hs;
   assign vga_vs      = r_vga_vs;
   assign vga_blank_n = r_blank_n;
   assign vga_sync_n  = 1'b0;
   assign vga_clk     = u_tim_if.phase;
   assign irq_mid     = r_irq_mid;
   assign irq_vblank  = r_irq_vblank;

endmodule
